// File: rtl/ls_mem_sched_if.sv
// Purpose: bundles the two decode enqueue slots, the data-memory request/ack
//   port and the completion/occupancy outputs of ls_mem_sched.
// Ports: master = scheduler side, slave = decode + memory + writeback side.
interface ls_mem_sched_if #(
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // decode slots
  logic                  ls_valid1_i;
  logic [2:0]            ls_type1_i;
  logic [TAG_WIDTH-1:0]  tag1_i;
  logic [ADDR_WIDTH-1:0] addr1_i;
  logic [DATA_WIDTH-1:0] wdata1_i;
  logic                  ls_valid2_i;
  logic [2:0]            ls_type2_i;
  logic [TAG_WIDTH-1:0]  tag2_i;
  logic [ADDR_WIDTH-1:0] addr2_i;
  logic [DATA_WIDTH-1:0] wdata2_i;
  logic                  ready_o;
  // memory port
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [1:0]            mem_size_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  // completion
  logic                  done_valid_o;
  logic [TAG_WIDTH-1:0]  done_tag_o;
  logic [DATA_WIDTH-1:0] done_rdata_o;
  logic [CW-1:0]         count_o;

  modport master (
    input  ls_valid1_i, ls_type1_i, tag1_i, addr1_i, wdata1_i,
    input  ls_valid2_i, ls_type2_i, tag2_i, addr2_i, wdata2_i,
    output ready_o,
    output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i,
    output done_valid_o, done_tag_o, done_rdata_o, count_o
  );

  modport slave (
    output ls_valid1_i, ls_type1_i, tag1_i, addr1_i, wdata1_i,
    output ls_valid2_i, ls_type2_i, tag2_i, addr2_i, wdata2_i,
    input  ready_o,
    input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i,
    input  done_valid_o, done_tag_o, done_rdata_o, count_o
  );
endinterface

// File: rtl/ls_mem_sched.sv
// Purpose: in-order load/store queue feeding one data-memory port; returns
//   tagged, sign-extended load data (0 for stores) one cycle after each ack.
// Latency: enqueue into empty queue -> mem_req_o two edges later; one op per 2 cycles max.
// Backpressure: ready_o=0 when fewer than two free entries; a pair offered then is dropped whole.
// Ports: clk_i, rst_i (sync, active-high); bus = ls_mem_sched_if.master.
module ls_mem_sched #(
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ls_mem_sched_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [2:0]            q_type  [DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag   [DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] q_wdata [DEPTH];

  logic [PW-1:0] head, tail, slot2_idx;
  logic [CW-1:0] count, n_wr;
  logic          ready, wr1, wr2, issue, pop;
  logic [2:0]    head_type;
  logic [1:0]    head_size;
  logic [DATA_WIDTH-1:0] ext_rdata;

  logic                  mem_req, mem_we;
  logic [1:0]            mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  done_valid;
  logic [TAG_WIDTH-1:0]  done_tag;
  logic [DATA_WIDTH-1:0] done_rdata;

  assign ready = (count <= CW'(DEPTH - 2));

  // Type 111 is a decode bubble, not an op; it never takes an entry.
  assign wr1  = ready && bus.ls_valid1_i && (bus.ls_type1_i != 3'b111);
  assign wr2  = ready && bus.ls_valid2_i && (bus.ls_type2_i != 3'b111);
  assign n_wr = CW'(wr1) + CW'(wr2);
  // Slot 2 packs down to tail when slot 1 writes nothing, keeping the queue dense.
  assign slot2_idx = wr1 ? tail + PW'(1) : tail;

  assign head_type = q_type[head];

  always_comb begin
    head_size = 2'b10;
    case (head_type[1:0])
      2'b01:   head_size = 2'b01;
      2'b10:   head_size = 2'b00;
      default: head_size = 2'b10;
    endcase
  end

  always_comb begin
    ext_rdata = '0;
    case (head_type)
      3'b000:  ext_rdata = bus.mem_rdata_i;
      3'b001:  ext_rdata = {{(DATA_WIDTH-16){bus.mem_rdata_i[15]}}, bus.mem_rdata_i[15:0]};
      3'b010:  ext_rdata = {{(DATA_WIDTH-8){bus.mem_rdata_i[7]}}, bus.mem_rdata_i[7:0]};
      default: ext_rdata = '0;
    endcase
  end

  // FSM: IDLE launches the head entry, BUSY waits for the ack and pops.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        state_next = BUSY;
        issue      = 1'b1;
      end
      BUSY: if (bus.mem_ack_i) begin
        state_next = IDLE;
        pop        = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Entry storage carries no reset; validity is tracked by head/tail/count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr1) begin
      q_type[tail]  <= bus.ls_type1_i;
      q_tag[tail]   <= bus.tag1_i;
      q_addr[tail]  <= bus.addr1_i;
      q_wdata[tail] <= bus.wdata1_i;
    end
    if (!rst_i && wr2) begin
      q_type[slot2_idx]  <= bus.ls_type2_i;
      q_tag[slot2_idx]   <= bus.tag2_i;
      q_addr[slot2_idx]  <= bus.addr2_i;
      q_wdata[slot2_idx] <= bus.wdata2_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(n_wr);
      count <= count + n_wr - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= head_type[2];
      mem_size  <= head_size;
      mem_addr  <= q_addr[head];
      mem_wdata <= q_wdata[head];
    end else if (pop) begin
      mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_valid <= 1'b0;
      done_tag   <= '0;
      done_rdata <= '0;
    end else begin
      done_valid <= pop;
      if (pop) begin
        done_tag   <= q_tag[head];
        done_rdata <= ext_rdata;
      end
    end
  end

  assign bus.ready_o      = ready;
  assign bus.count_o      = count;
  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_size_o   = mem_size;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.done_valid_o = done_valid;
  assign bus.done_tag_o   = done_tag;
  assign bus.done_rdata_o = done_rdata;
endmodule

// File: tb/tb_ls_mem_sched.sv
module tb_ls_mem_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ls_mem_sched_if #(.DEPTH(8), .TAG_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  ls_mem_sched #(.DEPTH(8), .TAG_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  t;
    logic [4:0]  tag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;   // what the memory model returns for this op
  } op_t;

  localparam op_t NOP = '0;

  op_t req_q[$];
  op_t done_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  logic mem_en = 1'b0;
  int   ack_dly = 2;
  logic resp_ack = 1'b0;
  logic idle_ack = 1'b0;

  assign bus.mem_ack_i = resp_ack | idle_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [2:0] t, input logic [4:0] tag,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata);
    op_t o;
    o.v = 1'b1; o.t = t; o.tag = tag; o.addr = addr; o.wdata = wdata; o.rdata = rdata;
    return o;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] t, input logic [31:0] r);
    case (t)
      3'b000:  return r;
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b010:  return {{24{r[7]}}, r[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] exp_size(input logic [2:0] t);
    case (t[1:0])
      2'b00:   return 2'b10;
      2'b01:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Called at posedge+1; returns at the posedge+1 after the enqueue edge.
  task automatic push(input op_t a, input op_t b);
    bus.ls_valid1_i = a.v; bus.ls_type1_i = a.t; bus.tag1_i = a.tag;
    bus.addr1_i = a.addr;  bus.wdata1_i = a.wdata;
    bus.ls_valid2_i = b.v; bus.ls_type2_i = b.t; bus.tag2_i = b.tag;
    bus.addr2_i = b.addr;  bus.wdata2_i = b.wdata;
    @(negedge clk);
    if (bus.ready_o) begin
      if (a.v && a.t != 3'b111) begin req_q.push_back(a); done_q.push_back(a); end
      if (b.v && b.t != 3'b111) begin req_q.push_back(b); done_q.push_back(b); end
    end
    @(posedge clk); #1;
    bus.ls_valid1_i = 1'b0;
    bus.ls_valid2_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k = 0;
    while ((req_q.size() != 0 || done_q.size() != 0) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_timeout", 64'(req_q.size() + done_q.size()), 0);
    idle(2);
  endtask

  // Memory model: checks each request against the scoreboard, holds it
  // ack_dly cycles, then acks with the op's read data.
  initial begin
    op_t r;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_en && bus.mem_req_o === 1'b1) begin
        r = NOP;
        if (req_q.size() == 0) chk("req_unexpected", bus.mem_req_o, 0);
        else r = req_q.pop_front();
        chk("req_we",   bus.mem_we_o,   r.t[2]);
        chk("req_size", bus.mem_size_o, exp_size(r.t));
        chk("req_addr", bus.mem_addr_o, r.addr);
        if (r.t[2]) chk("req_wdata", bus.mem_wdata_o, r.wdata);
        for (int i = 1; i < ack_dly; i++) begin
          @(negedge clk);
          chk("req_hold", {bus.mem_req_o, bus.mem_addr_o}, {1'b1, r.addr});
        end
        resp_ack = 1'b1;
        bus.mem_rdata_i = r.rdata;
        @(negedge clk);
        resp_ack = 1'b0;
        bus.mem_rdata_i = '0;
        chk("req_drop", bus.mem_req_o, 0);
      end
    end
  end

  // Completion monitor.
  initial begin
    op_t d;
    forever begin
      @(negedge clk);
      if (bus.done_valid_o === 1'b1) begin
        if (done_q.size() == 0) chk("done_unexpected", bus.done_valid_o, 0);
        else begin
          d = done_q.pop_front();
          chk("done_tag",   bus.done_tag_o,   d.tag);
          chk("done_rdata", bus.done_rdata_o, exp_rd(d.t, d.rdata));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    logic exp_rdy;
    rst = 1'b1;
    bus.ls_valid1_i = 0; bus.ls_type1_i = 0; bus.tag1_i = 0; bus.addr1_i = 0; bus.wdata1_i = 0;
    bus.ls_valid2_i = 0; bus.ls_type2_i = 0; bus.tag2_i = 0; bus.addr2_i = 0; bus.wdata2_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_count", bus.count_o, 0);
    chk("rst_req",   bus.mem_req_o, 0);
    chk("rst_mem",   {bus.mem_we_o, bus.mem_size_o, bus.mem_addr_o, bus.mem_wdata_o}, 0);
    chk("rst_done",  {bus.done_valid_o, bus.done_tag_o, bus.done_rdata_o}, 0);
    rst = 1'b0;
    idle(1);

    // Single LW: request two edges after enqueue, ack two cycles later.
    mem_en = 1'b1; ack_dly = 2;
    push(mk(3'b000, 5'd3, 32'h100, 32'h0, 32'h8765_4321), NOP);
    @(negedge clk); chk("lat_edge1", bus.mem_req_o, 0);
    @(negedge clk); chk("lat_edge2", bus.mem_req_o, 1);
    drain();

    // SB + LB in one cycle: slot order preserved, LB sign-extends, SB returns 0.
    push(mk(3'b110, 5'd1, 32'h200, 32'h0000_00AB, 32'hDEAD_BEEF),
         mk(3'b010, 5'd2, 32'h204, 32'h0, 32'h0000_0080));
    drain();

    // Half-word sign extension at both polarities.
    ack_dly = 1;
    push(mk(3'b001, 5'd4, 32'h300, 32'h0, 32'h0000_7FFF), NOP);
    push(mk(3'b001, 5'd5, 32'h302, 32'h0, 32'h0001_8000), NOP);
    drain();

    // Fill to 7 with acks held: ready drops, an offered pair is not taken.
    mem_en = 1'b0; ack_dly = 3;
    cnt = 0;
    push(mk(3'b000, 5'd10, 32'h400, 32'h0, 32'h1111_0010), NOP);
    cnt = 1;
    chk("fill_count1", bus.count_o, 64'(cnt));
    for (int i = 0; i < 4; i++) begin
      exp_rdy = ((8 - cnt) >= 2);
      chk("fill_ready", bus.ready_o, exp_rdy);
      push(mk(3'b000, 5'(11 + 2*i), 32'h410 + 32'(8*i), 32'h0, 32'h2222_0000 + 32'(i)),
           mk(3'b100, 5'(12 + 2*i), 32'h414 + 32'(8*i), 32'h5A5A_0000 + 32'(i), 32'h0));
      if (exp_rdy) cnt += 2;
      chk("fill_count", bus.count_o, 64'(cnt));
    end
    chk("fill_ready7", bus.ready_o, 0);
    mem_en = 1'b1;
    drain();

    // Fill to 8 with pairs, then drain across the pointer wrap.
    mem_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      exp_rdy = ((8 - cnt) >= 2);
      chk("fill8_ready", bus.ready_o, exp_rdy);
      push(mk(3'b010, 5'(20 + 2*i), 32'h500 + 32'(8*i), 32'h0, 32'h0000_00F0 + 32'(i)),
           mk(3'b000, 5'(21 + 2*i), 32'h504 + 32'(8*i), 32'h0, 32'h3333_0000 + 32'(i)));
      if (exp_rdy) cnt += 2;
      chk("fill8_count", bus.count_o, 64'(cnt));
    end
    mem_en = 1'b1; ack_dly = 1;
    drain();

    // Ack while IDLE with an empty queue is ignored.
    mem_en = 1'b0;
    idle_ack = 1'b1;
    idle(3);
    idle_ack = 1'b0;
    chk("idle_ack_count", bus.count_o, 0);
    chk("idle_ack_req",   bus.mem_req_o, 0);

    // A type-111 slot takes no entry.
    mem_en = 1'b1;
    push(mk(3'b111, 5'd6, 32'h600, 32'h0, 32'h0),
         mk(3'b100, 5'd7, 32'h604, 32'h1234_5678, 32'h0));
    chk("type111_count", bus.count_o, 1);
    drain();

    // Reset while BUSY with three entries: everything discarded, no done pulse.
    mem_en = 1'b0;
    push(mk(3'b000, 5'd8, 32'h700, 32'h0, 32'h0), mk(3'b000, 5'd9, 32'h704, 32'h0, 32'h0));
    push(mk(3'b000, 5'd11, 32'h708, 32'h0, 32'h0), NOP);
    chk("busy_req",   bus.mem_req_o, 1);
    chk("busy_count", bus.count_o, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    req_q.delete();
    done_q.delete();
    chk("rstbusy_req",   bus.mem_req_o, 0);
    chk("rstbusy_count", bus.count_o, 0);
    chk("rstbusy_ready", bus.ready_o, 1);
    chk("rstbusy_done",  bus.done_valid_o, 0);
    rst = 1'b0;
    idle(4);
    chk("post_rst_count", bus.count_o, 0);
    chk("post_rst_req",   bus.mem_req_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ls_mem_sched.md
Name: ls_mem_sched

Overview:
- In-order load/store scheduler between the 2-wide decode stage and a single data-memory port.
- Accepts up to two parsed load/store ops per cycle, using the 3-bit ls_type encoding produced by instruction parsing. Buffers them in a circular queue.
- Issues them one at a time over a req/ack handshake.
- Returns load data, sign-extended per type, with the op's tag.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- TAG_WIDTH, 5, width of the ROB tag carried with each op.
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, store/load data width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ls_valid1_i  in  1  slot-1 op valid.
- ls_type1_i  in  3  slot-1 type: 000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB, 111 none.
- tag1_i  in  TAG_WIDTH  slot-1 tag.
- addr1_i  in  ADDR_WIDTH  slot-1 effective address.
- wdata1_i  in  DATA_WIDTH  slot-1 store data.
- ls_valid2_i, ls_type2_i, tag2_i, addr2_i, wdata2_i  in  same widths  slot-2 equivalents.
- ready_o  out  1  queue can accept two ops this cycle.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = store.
- mem_size_o  out  2  00 byte, 01 half, 10 word.
- mem_addr_o  out  ADDR_WIDTH  request address.
- mem_wdata_o  out  DATA_WIDTH  store data.
- mem_ack_i  in  1  memory accepted/completed the request.
- mem_rdata_i  in  DATA_WIDTH  load data, LSB-aligned; valid in the ack cycle.
- done_valid_o  out  1  one-cycle completion pulse.
- done_tag_o  out  TAG_WIDTH  completed op tag.
- done_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores.
- count_o  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: the following are cleared at the first edge with rst_i=1.
  - Queue empties: head, tail and count go to 0. State goes to IDLE.
  - mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o go to 0.
  - done_valid_o, done_tag_o, done_rdata_o go to 0.
  - ready_o=1 after reset, as a combinational function of count.
- ready_o = (DEPTH - count) >= 2.
- Enqueue, at an edge with ready_o=1:
  - A slot is written if ls_valid=1 and ls_type != 111.
  - If both slots are valid, slot 1 is written at tail and slot 2 at tail+1. Tail advances by the number written.
  - Pointers wrap modulo DEPTH.
- Enqueue with ready_o=0: both slots are ignored (no partial accept). Upstream must hold and retry.
- Queue fields per entry: type, tag, addr, wdata.
- FSM, two states.
  - IDLE: if count>0 at an edge, go to BUSY and register head entry fields onto the mem_* outputs with mem_req_o=1.
    - mem_we_o = type[2].
    - mem_size_o = 10 for types x00, 01 for x01, 00 for x10.
  - IDLE: an op enqueued at edge E into an empty queue produces mem_req_o=1 starting after edge E+1.
  - BUSY: mem_* outputs are held stable until mem_ack_i=1 is sampled.
  - BUSY, at the ack edge:
    - head is popped and state returns to IDLE; mem_req_o goes to 0.
    - done_valid_o=1 for exactly the next cycle, with done_tag_o = the head tag.
    - done_rdata_o: LW gives rdata; LH gives sign-extended rdata[15:0]; LB gives sign-extended rdata[7:0]; stores give 0.
- Throughput: at most one op per 2 cycles, because of the mandatory IDLE bubble.
- Simultaneous enqueue and pop at the same edge: count_next = count + n_written - 1. The enqueue decision uses the pre-edge ready_o.
- Full queue: when count = DEPTH-1 or DEPTH, ready_o=0. Issue continues normally.
- Empty queue: FSM stays in IDLE with mem_req_o=0.
- An ack while in IDLE is ignored.
- Reset in BUSY: the request is abandoned (mem_req_o drops next cycle), the queue is discarded, and no done pulse is produced. The memory side must tolerate the abandoned request.

Test Plan:
- Reset, then LW tag 3 addr 0x100 on slot 1 only; ack 2 cycles after req with rdata 0x8765_4321 -> mem_req_o rises 2 edges after enqueue with we=0, size=10. The cycle after ack shows done_valid_o=1, tag 3, rdata 0x87654321.
- Same cycle: slot 1 SB tag 1 wdata 0xAB, slot 2 LB tag 2; LB ack rdata 0x0000_0080 -> the SB issues first (we=1, size=00), then the LB. The LB completes with done_rdata_o 0xFFFF_FF80; the SB completes with 0.
- LH with rdata 0x0000_7FFF, then LH with rdata 0x0001_8000 -> done_rdata_o 0x0000_7FFF, then 0xFFFF_8000.
- Enqueue 2 ops per cycle with mem_ack_i=0 and DEPTH=8 -> ready_o drops when count=7 or 8. A pair offered with ready_o=0 is not queued. Release acks and confirm tag order is preserved across pointer wrap.
- One enqueue slot with ls_valid=1 and type 111, plus one valid SW -> count increments by 1 only.
- Assert rst_i while BUSY with 3 entries queued -> after the edge, mem_req_o=0, count_o=0, ready_o=1, and no done_valid_o.
